// File: rtl/mac_cfg_pkg.sv
// Shared types and constants for the MAC address configuration sequencer:
// FSM states, slave register offsets, AXI response codes and word-table helper.
package mac_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } state_e;

    localparam logic [7:0] MAC_LO_OFS = 8'h00;
    localparam logic [7:0] MAC_HI_OFS = 8'h04;
    localparam logic [7:0] CTRL_OFS   = 8'h08;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int NUM_WR_WORDS = 3;

    // Register offset of each entry in the write sequence.
    function automatic logic [7:0] word_ofs(input logic [1:0] idx);
        logic [7:0] ofs;
        case (idx)
            2'd0:    ofs = MAC_LO_OFS;
            2'd1:    ofs = MAC_HI_OFS;
            default: ofs = CTRL_OFS;
        endcase
        return ofs;
    endfunction

endpackage

// File: rtl/mac_cfg_arbiter.sv
// Two-port fixed-priority arbiter: port 0 wins ties. The winner is captured
// while the sequencer is idle and acknowledged with a one-cycle ready pulse.
module mac_cfg_arbiter (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       arb_en_i,
    input  logic [1:0] req_valid_i,
    input  logic       ack_i,
    output logic       any_req_o,
    output logic       grant_id_o,
    output logic [1:0] req_ready_o
);

    logic sel_q;

    assign any_req_o  = |req_valid_i;
    assign grant_id_o = sel_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_q <= 1'b0;
        end else if (arb_en_i && any_req_o) begin
            sel_q <= ~req_valid_i[0];
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready_o[gi] = ack_i && (sel_q == gi[0]);
        end
    endgenerate

endmodule

// File: rtl/mac_addr_cfg_sequencer.sv
// AXI4-Lite master that writes a 48-bit MAC (low word, high half-word, commit)
// into the address slave. Define MAC_CFG_READBACK_EN to verify both MAC words by readback.
module mac_addr_cfg_sequencer
    import mac_cfg_pkg::*;
#(
    parameter int                          C_M_AXI_ADDR_WIDTH = 32,
    parameter int                          C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_SLV_BASE_ADDR  = '0,
    parameter logic [31:0]                 C_COMMIT_VALUE     = 32'h0000_0001
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic                            req0_valid,
    input  logic [47:0]                     req0_mac,
    output logic                            req0_ready,
    input  logic                            req1_valid,
    input  logic [47:0]                     req1_mac,
    output logic                            req1_ready,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic                            grant_id,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    generate
        if (C_M_AXI_DATA_WIDTH != 32) begin : g_bad_width
            $error("mac_addr_cfg_sequencer: C_M_AXI_DATA_WIDTH must be 32");
        end
    endgenerate

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [47:0] mac_q, mac_d;
    logic        err_q, err_d;
    logic        aw_q, aw_d;
    logic        w_q, w_d;
    logic        any_req;
    logic        arb_id;
    logic [1:0]  arb_ready;
    logic [31:0] wr_data;
    logic [C_M_AXI_ADDR_WIDTH-1:0] word_addr;

    mac_cfg_arbiter u_arbiter (
        .clk_i       (ACLK),
        .rst_i       (ARESET),
        .arb_en_i    (state_q == IDLE),
        .req_valid_i ({req1_valid, req0_valid}),
        .ack_i       (state_q == GRANT),
        .any_req_o   (any_req),
        .grant_id_o  (arb_id),
        .req_ready_o (arb_ready)
    );

    always_comb begin
        case (idx_q)
            2'd0:    wr_data = mac_q[31:0];
            2'd1:    wr_data = {16'h0000, mac_q[47:32]};
            default: wr_data = C_COMMIT_VALUE;
        endcase
    end

    assign word_addr = C_SLV_BASE_ADDR + {{(C_M_AXI_ADDR_WIDTH-8){1'b0}}, word_ofs(idx_q)};

`ifdef MAC_CFG_READBACK_EN
    logic ar_q, ar_d;
    logic rd_ok;

    assign rd_ok = (M_AXI_RRESP == RESP_OKAY) && (M_AXI_RDATA == wr_data);
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mac_d   = mac_q;
        err_d   = err_q;
        aw_d    = aw_q;
        w_d     = w_q;
`ifdef MAC_CFG_READBACK_EN
        ar_d    = ar_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                mac_d   = arb_id ? req1_mac : req0_mac;
                idx_d   = 2'd0;
                err_d   = 1'b0;
                aw_d    = 1'b1;
                w_d     = 1'b1;
                state_d = WR_ADDR_DATA;
            end
            WR_ADDR_DATA: begin
                // Address and data channels complete independently.
                if (M_AXI_AWREADY) aw_d = 1'b0;
                if (M_AXI_WREADY)  w_d  = 1'b0;
                if (!aw_d && !w_d) begin
                    state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP != RESP_OKAY) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (idx_q != 2'(NUM_WR_WORDS - 1)) begin
                        idx_d   = idx_q + 2'd1;
                        aw_d    = 1'b1;
                        w_d     = 1'b1;
                        state_d = WR_ADDR_DATA;
                    end else begin
`ifdef MAC_CFG_READBACK_EN
                        idx_d   = 2'd0;
                        ar_d    = 1'b1;
                        state_d = RD_ADDR;
`else
                        state_d = DONE;
`endif
                    end
                end
            end
`ifdef MAC_CFG_READBACK_EN
            RD_ADDR: begin
                if (M_AXI_ARREADY) begin
                    ar_d    = 1'b0;
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                // Only the two MAC words are read back; the commit word is not.
                if (M_AXI_RVALID) begin
                    if (!rd_ok) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else if (idx_q == 2'd1) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        ar_d    = 1'b1;
                        state_d = RD_ADDR;
                    end
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            mac_q   <= 48'h0;
            err_q   <= 1'b0;
            aw_q    <= 1'b0;
            w_q     <= 1'b0;
`ifdef MAC_CFG_READBACK_EN
            ar_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mac_q   <= mac_d;
            err_q   <= err_d;
            aw_q    <= aw_d;
            w_q     <= w_d;
`ifdef MAC_CFG_READBACK_EN
            ar_q    <= ar_d;
`endif
        end
    end

    assign req0_ready    = arb_ready[0];
    assign req1_ready    = arb_ready[1];
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign err           = (state_q == DONE) && err_q;
    assign grant_id      = arb_id;

    assign M_AXI_AWADDR  = aw_q ? word_addr : '0;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = aw_q;
    assign M_AXI_WDATA   = w_q ? wr_data : '0;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = w_q;
    assign M_AXI_BREADY  = (state_q == WR_RESP);
    assign M_AXI_ARPROT  = 3'b000;

`ifdef MAC_CFG_READBACK_EN
    assign M_AXI_ARADDR  = ar_q ? word_addr : '0;
    assign M_AXI_ARVALID = ar_q;
    assign M_AXI_RREADY  = (state_q == RD_DATA);
`else
    logic unused_rd;
    assign unused_rd     = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
    assign M_AXI_ARADDR  = '0;
    assign M_AXI_ARVALID = 1'b0;
    assign M_AXI_RREADY  = 1'b0;
`endif

endmodule
